// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: recovers hex digits from a multiplexed, active-low
// 7-segment display scan. Inputs are registered once, each digit pattern must
// stay stable for STABLE_CYC registered samples before it is captured, and a
// frame completes once all four digits have been captured.
module seg7_scan_decoder #(
    parameter int unsigned STABLE_CYC = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  seg_in,
    input  logic [3:0]  an_in,
    output logic [15:0] hex_out,
    output logic [3:0]  digit_err,
    output logic        frame_valid,
    output logic        update
);

    localparam logic [7:0] C_STABLE = 8'(STABLE_CYC);

    logic [6:0]  r_seg_q;
    logic [3:0]  r_an_q;
    logic [10:0] r_prev;
    logic [7:0]  r_cnt;
    logic [3:0]  r_seen;

    logic        w_onehot;
    logic [1:0]  w_idx;
    logic        w_same;
    logic        w_capture;
    logic        w_legal;
    logic [3:0]  w_nib;
    logic [3:0]  w_cap_mask;

    // Select the active digit; blank or multiple enables mean no digit.
    always_comb begin
        w_onehot = 1'b1;
        w_idx    = 2'd0;
        case (r_an_q)
            4'b1110: w_idx = 2'd0;
            4'b1101: w_idx = 2'd1;
            4'b1011: w_idx = 2'd2;
            4'b0111: w_idx = 2'd3;
            default: w_onehot = 1'b0;
        endcase
    end

    // Map active-low segment codes to hex values; anything else is illegal.
    always_comb begin
        w_legal = 1'b1;
        w_nib   = 4'h0;
        case (r_seg_q)
            7'h40: w_nib = 4'h0;
            7'h79: w_nib = 4'h1;
            7'h24: w_nib = 4'h2;
            7'h30: w_nib = 4'h3;
            7'h19: w_nib = 4'h4;
            7'h12: w_nib = 4'h5;
            7'h02: w_nib = 4'h6;
            7'h78: w_nib = 4'h7;
            7'h00: w_nib = 4'h8;
            7'h10: w_nib = 4'h9;
            7'h08: w_nib = 4'hA;
            7'h03: w_nib = 4'hB;
            7'h46: w_nib = 4'hC;
            7'h21: w_nib = 4'hD;
            7'h06: w_nib = 4'hE;
            7'h0E: w_nib = 4'hF;
            default: w_legal = 1'b0;
        endcase
    end

    // Capture fires on the edge where the counter steps up to STABLE_CYC,
    // so a saturated counter never re-captures the same pattern.
    always_comb begin
        w_same     = ({r_an_q, r_seg_q} == r_prev);
        w_capture  = w_onehot && w_same && (r_cnt == C_STABLE - 8'd1);
        w_cap_mask = w_capture ? (4'b0001 << w_idx) : 4'b0000;
    end

    // Input registers, previous-sample history and stability counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_seg_q <= 7'h7F;
            r_an_q  <= 4'hF;
            r_prev  <= {4'hF, 7'h7F};
            r_cnt   <= '0;
        end else begin
            r_seg_q <= seg_in;
            r_an_q  <= an_in;
            r_prev  <= {r_an_q, r_seg_q};
            if (!w_onehot)
                r_cnt <= '0;
            else if (!w_same)
                r_cnt <= 8'd1;
            else if (r_cnt < C_STABLE)
                r_cnt <= r_cnt + 8'd1;
        end
    end

    // Digit capture, seen tracking and frame completion.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hex_out     <= '0;
            digit_err   <= '0;
            frame_valid <= 1'b0;
            update      <= 1'b0;
            r_seen      <= '0;
        end else begin
            update <= 1'b0;
            // A capture in the clearing cycle starts the next frame's seen set.
            if (r_seen == 4'hF) begin
                update      <= 1'b1;
                frame_valid <= ~|digit_err;
                r_seen      <= w_cap_mask;
            end else begin
                r_seen <= r_seen | w_cap_mask;
            end
            for (int unsigned i = 0; i < 4; i++) begin
                if (w_cap_mask[i]) begin
                    if (w_legal) begin
                        hex_out[4*i +: 4] <= w_nib;
                        digit_err[i]      <= 1'b0;
                    end else begin
                        digit_err[i]      <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed testbench for seg7_scan_decoder with STABLE_CYC = 4.
module tb_seg7_scan_decoder;

    logic        clk;
    logic        rst_n;
    logic [6:0]  seg_in;
    logic [3:0]  an_in;
    logic [15:0] hex_out;
    logic [3:0]  digit_err;
    logic        frame_valid;
    logic        update;

    int checks;
    int errors;
    int upd_cnt;
    int base;

    seg7_scan_decoder #(.STABLE_CYC(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .an_in       (an_in),
        .hex_out     (hex_out),
        .digit_err   (digit_err),
        .frame_valid (frame_valid),
        .update      (update)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count update pulses, sampled on the falling edge.
    always @(negedge clk) begin
        if (update === 1'b1) upd_cnt++;
    end

    task automatic hold(input logic [3:0] an, input logic [6:0] seg, input int n);
        an_in  = an;
        seg_in = seg;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        upd_cnt = 0;
        rst_n   = 1'b0;
        an_in   = 4'hF;
        seg_in  = 7'h7F;

        // Reset state
        hold(4'hF, 7'h7F, 3);
        check("rst_hex", hex_out, 16'h0000);
        check("rst_err", 16'(digit_err), 16'h0);
        check("rst_fv", 16'(frame_valid), 16'h0);
        check("rst_upd", 16'(update), 16'h0);
        rst_n = 1'b1;

        // Frame 1,2,3,4
        base = upd_cnt;
        hold(4'b1110, 7'h79, 6);
        hold(4'b1101, 7'h24, 6);
        hold(4'b1011, 7'h30, 6);
        hold(4'b0111, 7'h19, 6);
        hold(4'hF, 7'h7F, 2);
        check("f1_hex", hex_out, 16'h4321);
        check("f1_err", 16'(digit_err), 16'h0);
        check("f1_fv", 16'(frame_valid), 16'h1);
        check("f1_updcnt", 16'(upd_cnt - base), 16'd1);

        // Frame A,B,<illegal>,D
        base = upd_cnt;
        hold(4'b1110, 7'h08, 6);
        hold(4'b1101, 7'h03, 6);
        hold(4'b1011, 7'h7F, 6);
        hold(4'b0111, 7'h21, 6);
        hold(4'hF, 7'h7F, 2);
        check("f2_hex", hex_out, 16'hD3BA);
        check("f2_err", 16'(digit_err), 16'h4);
        check("f2_fv", 16'(frame_valid), 16'h0);
        check("f2_updcnt", 16'(upd_cnt - base), 16'd1);

        // Too-short pattern: no capture
        base = upd_cnt;
        hold(4'b1110, 7'h12, 3);
        hold(4'hF, 7'h7F, 4);
        check("short_hex", hex_out, 16'hD3BA);
        check("short_err", 16'(digit_err), 16'h4);

        // Two digits selected: no capture
        hold(4'b1100, 7'h40, 10);
        hold(4'hF, 7'h7F, 2);
        check("multi_hex", hex_out, 16'hD3BA);
        check("multi_updcnt", 16'(upd_cnt - base), 16'd0);

        // Partial frame 5,6,7 then reset
        hold(4'b1110, 7'h12, 6);
        hold(4'b1101, 7'h02, 6);
        hold(4'b1011, 7'h78, 6);
        hold(4'hF, 7'h7F, 2);
        check("part_hex", hex_out, 16'hD765);
        check("part_err", 16'(digit_err), 16'h0);
        check("part_updcnt", 16'(upd_cnt - base), 16'd0);
        rst_n = 1'b0;
        hold(4'hF, 7'h7F, 1);
        rst_n = 1'b1;
        check("rst2_hex", hex_out, 16'h0000);
        check("rst2_err", 16'(digit_err), 16'h0);
        check("rst2_fv", 16'(frame_valid), 16'h0);
        check("rst2_upd", 16'(update), 16'h0);

        // After reset, digit 3 alone does not complete a frame
        base = upd_cnt;
        hold(4'b0111, 7'h10, 6);
        hold(4'hF, 7'h7F, 2);
        check("post_d3_hex", hex_out, 16'h9000);
        check("post_d3_updcnt", 16'(upd_cnt - base), 16'd0);
        hold(4'b1110, 7'h00, 6);
        hold(4'b1101, 7'h0E, 6);
        hold(4'b1011, 7'h06, 6);
        hold(4'hF, 7'h7F, 2);
        check("post_hex", hex_out, 16'h9EF8);
        check("post_fv", 16'(frame_valid), 16'h1);
        check("post_updcnt", 16'(upd_cnt - base), 16'd1);

        // Long hold, change and restore, then exact latency on the last digit
        base = upd_cnt;
        hold(4'b1101, 7'h30, 20);
        check("long_hex", hex_out, 16'h9E38);
        hold(4'b1101, 7'h7F, 6);
        check("chg_err", 16'(digit_err), 16'h2);
        check("chg_hex", hex_out, 16'h9E38);
        hold(4'b1101, 7'h30, 6);
        check("restore_err", 16'(digit_err), 16'h0);
        hold(4'b1110, 7'h79, 6);
        hold(4'b1011, 7'h24, 6);
        check("lat_pre_hex", hex_out, 16'h9231);
        check("lat_pre_updcnt", 16'(upd_cnt - base), 16'd0);
        hold(4'b0111, 7'h78, 4);
        check("lat_e4_hex", hex_out, 16'h9231);
        hold(4'b0111, 7'h78, 1);
        check("lat_e5_hex", hex_out, 16'h7231);
        check("lat_e5_upd", 16'(update), 16'h0);
        hold(4'b0111, 7'h78, 1);
        check("lat_e6_upd", 16'(update), 16'h1);
        check("lat_e6_fv", 16'(frame_valid), 16'h1);
        hold(4'b0111, 7'h78, 1);
        check("lat_e7_upd", 16'(update), 16'h0);
        hold(4'hF, 7'h7F, 2);
        check("lat_updcnt", 16'(upd_cnt - base), 16'd1);
        check("lat_fv_hold", 16'(frame_valid), 16'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
